traffic_sensor_conditioner: RTL and testbench



---
 rtl/traffic_sensor_conditioner.sv | 131 +++++++++++++
 tb/tb_traffic_sensor_conditioner.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sensor_conditioner.sv
// Debounced, synchronized vehicle-detector front end with per-lane arrival counters.
// Optional stuck-detector flagging is compiled in with `define SENSOR_STUCK_DET_EN.
module traffic_sensor_conditioner #(
  parameter int DEBOUNCE_CYC = 20,
  parameter int STUCK_CYC    = 600,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s1,
  input  logic             s2,
  input  logic             s3,
  input  logic             s4,
  input  logic             clr_cnt,
  output logic             t1,
  output logic             t2,
  output logic             t3,
  output logic             t4,
  output logic [3:0]       fault,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
  output logic [CNT_W-1:0] cnt4
);

  localparam int                DB_W     = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [3:0]       w_raw;
  logic [3:0]       r_sync1;
  logic [3:0]       r_sq;
  logic [3:0]       r_d;
  logic [3:0]       w_d_nxt;
  logic [3:0]       w_rise;
  logic [3:0]       w_fault;
  logic [DB_W-1:0]  r_db_cnt [4];
  logic [DB_W-1:0]  w_db_nxt [4];
  logic [CNT_W-1:0] r_cnt    [4];

  assign w_raw = {s4, s3, s2, s1};

  // The counter only advances while the synchronized level disagrees with the debounced one.
  always_comb begin
    w_d_nxt = r_d;
    for (int i = 0; i < 4; i++) begin
      w_db_nxt[i] = '0;
      if (r_sq[i] != r_d[i]) begin
        if (r_db_cnt[i] == DB_LAST) begin
          w_d_nxt[i]  = r_sq[i];
          w_db_nxt[i] = '0;
        end else begin
          w_db_nxt[i] = r_db_cnt[i] + DB_W'(1);
        end
      end else begin
        w_db_nxt[i] = '0;
      end
    end
  end

  assign w_rise = w_d_nxt & ~r_d;

  // Two-flop synchronizer and debounce state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 4'b0000;
      r_sq    <= 4'b0000;
      r_d     <= 4'b0000;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sq    <= r_sync1;
      r_d     <= w_d_nxt;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= w_db_nxt[i];
    end
  end

  // Arrival counters saturate; a clear beats a same-edge arrival.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else if (clr_cnt) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_rise[i] && (r_cnt[i] != CNT_MAX)) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

`ifdef SENSOR_STUCK_DET_EN
  localparam int               ST_W    = $clog2(STUCK_CYC + 1);
  localparam logic [ST_W-1:0]  ST_LAST = ST_W'(STUCK_CYC - 1);
  localparam logic [ST_W-1:0]  ST_SAT  = ST_W'(STUCK_CYC);

  logic [ST_W-1:0] r_st_cnt [4];
  logic [3:0]      r_fault;

  // Count edges since the debounced rise; the fault drops on the same edge the lane goes idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fault <= 4'b0000;
      for (int i = 0; i < 4; i++) r_st_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!w_d_nxt[i]) begin
          r_st_cnt[i] <= '0;
          r_fault[i]  <= 1'b0;
        end else if (!r_d[i]) begin
          r_st_cnt[i] <= '0;
        end else begin
          if (r_st_cnt[i] != ST_SAT) r_st_cnt[i] <= r_st_cnt[i] + ST_W'(1);
          if (r_st_cnt[i] == ST_LAST) r_fault[i] <= 1'b1;
        end
      end
    end
  end

  assign w_fault = r_fault;
`else
  assign w_fault = 4'b0000;
`endif

  assign fault            = w_fault;
  assign {t4, t3, t2, t1} = r_d | w_fault;
  assign cnt1             = r_cnt[0];
  assign cnt2             = r_cnt[1];
  assign cnt3             = r_cnt[2];
  assign cnt4             = r_cnt[3];

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Self-checking bench: directed scenarios plus randomized detector traffic compared
// every cycle against a sample-history model of the conditioner.
module tb_traffic_sensor_conditioner;

  localparam int DB  = 4;
  localparam int ST  = 32;
  localparam int CW  = 4;
  localparam int MAXC = (1 << CW) - 1;
`ifdef SENSOR_STUCK_DET_EN
  localparam bit STUCK_EN = 1'b1;
`else
  localparam bit STUCK_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [3:0]    s;
  logic          clr_cnt;
  logic          t1, t2, t3, t4;
  logic [3:0]    fault;
  logic [CW-1:0] cnt1, cnt2, cnt3, cnt4;

  int errors = 0;
  int checks = 0;

  // Reference state: raw-sample pipeline, sq history, debounced level, run length, counts.
  bit       ff1_m [4];
  bit       sq_m  [4];
  bit       hist  [4][DB];
  bit       d_m   [4];
  int       hi_len[4];
  int       cnt_m [4];

  traffic_sensor_conditioner #(.DEBOUNCE_CYC(DB), .STUCK_CYC(ST), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .s1(s[0]), .s2(s[1]), .s3(s[2]), .s4(s[3]),
    .clr_cnt(clr_cnt),
    .t1(t1), .t2(t2), .t3(t3), .t4(t4),
    .fault(fault),
    .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3), .cnt4(cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Next-edge behaviour: the debounced level flips once the last DB sq samples all disagree with it.
  task automatic model_step();
    for (int l = 0; l < 4; l++) begin
      if (!reset) begin
        ff1_m[l] = 1'b0; sq_m[l] = 1'b0; d_m[l] = 1'b0;
        hi_len[l] = 0; cnt_m[l] = 0;
        for (int i = 0; i < DB; i++) hist[l][i] = 1'b0;
      end else begin
        bit all_diff;
        bit prev;
        for (int i = DB - 1; i > 0; i--) hist[l][i] = hist[l][i-1];
        hist[l][0] = sq_m[l];
        all_diff = 1'b1;
        for (int i = 0; i < DB; i++) if (hist[l][i] == d_m[l]) all_diff = 1'b0;
        prev = d_m[l];
        if (all_diff) d_m[l] = ~d_m[l];
        if (d_m[l]) hi_len[l] = prev ? hi_len[l] + 1 : 0;
        else        hi_len[l] = 0;
        if (clr_cnt) cnt_m[l] = 0;
        else if (!prev && d_m[l] && cnt_m[l] < MAXC) cnt_m[l] = cnt_m[l] + 1;
        sq_m[l]  = ff1_m[l];
        ff1_m[l] = s[l];
      end
    end
  endtask

  task automatic compare_model();
    logic [3:0] f_exp;
    logic [3:0] t_exp;
    for (int l = 0; l < 4; l++) begin
      f_exp[l] = STUCK_EN && d_m[l] && (hi_len[l] >= ST);
      t_exp[l] = d_m[l] | f_exp[l];
    end
    chk("model_t", {28'd0, t4, t3, t2, t1}, {28'd0, t_exp});
    chk("model_fault", {28'd0, fault}, {28'd0, f_exp});
    chk("model_cnt1", {28'd0, cnt1}, 32'(cnt_m[0]));
    chk("model_cnt2", {28'd0, cnt2}, 32'(cnt_m[1]));
    chk("model_cnt3", {28'd0, cnt3}, 32'(cnt_m[2]));
    chk("model_cnt4", {28'd0, cnt4}, 32'(cnt_m[3]));
  endtask

  // One clock: inputs held across the rising edge, outputs checked at the falling edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(negedge clk);
      compare_model();
    end
  endtask

  int  hold [4];
  int  r;
  logic [31:0] f_stuck;

  initial begin
    reset = 1'b0; s = 4'hF; clr_cnt = 1'b0;
    f_stuck = 32'(STUCK_EN);

    // Reset with detectors active, then release.
    tick(3);
    chk("rst_t", {28'd0, t4, t3, t2, t1}, 32'h0);
    chk("rst_fault", {28'd0, fault}, 32'h0);
    chk("rst_cnt", {16'd0, cnt4, cnt3, cnt2, cnt1}, 32'h0);
    reset = 1'b1;
    tick(5);
    chk("pre_rise_t", {28'd0, t4, t3, t2, t1}, 32'h0);
    tick(1);
    chk("rise_t", {28'd0, t4, t3, t2, t1}, 32'hF);
    chk("rise_cnt", {16'd0, cnt4, cnt3, cnt2, cnt1}, 32'h1111);

    // Lane 2 clean rise and fall.
    s = 4'h0;
    tick(10);
    clr_cnt = 1'b1; tick(1); clr_cnt = 1'b0;
    s[1] = 1'b1;
    tick(5); chk("t2_before", 32'(t2), 32'd0);
    tick(1); chk("t2_rise", 32'(t2), 32'd1);
    chk("cnt2_one", 32'(cnt2), 32'd1);
    s[1] = 1'b0;
    tick(5); chk("t2_hold", 32'(t2), 32'd1);
    tick(1); chk("t2_fall", 32'(t2), 32'd0);
    chk("cnt2_keep", 32'(cnt2), 32'd1);

    // Lane 3 short pulse and short gap are filtered.
    s[2] = 1'b1; tick(3); s[2] = 1'b0;
    tick(10);
    chk("t3_pulse", 32'(t3), 32'd0);
    chk("cnt3_pulse", 32'(cnt3), 32'd0);
    s[2] = 1'b1; tick(10);
    chk("t3_high", 32'(t3), 32'd1);
    s[2] = 1'b0; tick(3); s[2] = 1'b1;
    tick(10);
    chk("t3_gap", 32'(t3), 32'd1);
    chk("cnt3_gap", 32'(cnt3), 32'd1);
    s[2] = 1'b0; tick(10);

    // Lane 1 stuck detection and release.
    s[0] = 1'b1;
    tick(6); chk("t1_rise", 32'(t1), 32'd1);
    tick(31); chk("fault_early", 32'(fault[0]), 32'd0);
    tick(1); chk("fault_set", 32'(fault[0]), f_stuck);
    tick(13);
    s[0] = 1'b0;
    tick(5); chk("t1_held", 32'(t1), 32'd1);
    chk("fault_held", 32'(fault[0]), f_stuck);
    tick(1); chk("t1_drop", 32'(t1), 32'd0);
    chk("fault_drop", 32'(fault[0]), 32'd0);

    // Lane 4 counter saturation, then clear colliding with a rise.
    clr_cnt = 1'b1; tick(1); clr_cnt = 1'b0;
    for (int p = 0; p < 17; p++) begin
      s[3] = 1'b1; tick(8);
      s[3] = 1'b0; tick(8);
    end
    tick(10);
    chk("cnt4_sat", 32'(cnt4), 32'd15);
    s[3] = 1'b1;
    tick(5);
    clr_cnt = 1'b1; tick(1); clr_cnt = 1'b0;
    chk("t4_clr_rise", 32'(t4), 32'd1);
    chk("cnt4_clr", 32'(cnt4), 32'd0);
    tick(1); chk("cnt4_clr_hold", 32'(cnt4), 32'd0);
    s[3] = 1'b0; tick(10);

    // Reset in the middle of a debounce window restarts qualification.
    s[0] = 1'b1;
    tick(2);
    reset = 1'b0; tick(1); reset = 1'b1;
    tick(5); chk("t1_requal", 32'(t1), 32'd0);
    tick(1); chk("t1_after_rst", 32'(t1), 32'd1);
    chk("cnt1_after_rst", 32'(cnt1), 32'd1);
    s[0] = 1'b0; tick(10);

    // Randomized traffic with occasional clears, resets and long holds.
    for (int l = 0; l < 4; l++) hold[l] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int l = 0; l < 4; l++) begin
        if (hold[l] == 0) begin
          s[l] = 1'($urandom_range(0, 1));
          r = int'($urandom_range(0, 9));
          if (r < 3)      hold[l] = int'($urandom_range(1, 3));
          else if (r < 9) hold[l] = int'($urandom_range(4, 12));
          else            hold[l] = int'($urandom_range(35, 60));
        end
        hold[l]--;
      end
      clr_cnt = ($urandom_range(0, 59) == 0);
      reset   = ($urandom_range(0, 499) != 0);
      tick(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
